lcd_sum_display: RTL and testbench
==================================

LCD_SUM_DISPLAY -- requirements
Module: lcd_sum_display

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values are multiples of 4 from 4 to 32.
REQ-002 SHALL have parameter E_CYC, default 12, number of clk cycles lcd_e is held high per nibble.
REQ-003 SHALL have parameter GAP_CYC, default 2000, number of idle clk cycles after each nibble.
REQ-004 SHALL have parameter PWR_CYC, default 750000, power-up wait in clk cycles.
REQ-005 SHALL have parameter CLR_CYC, default 82000, extra wait after the Clear Display byte.
REQ-006 SHALL have ports: clk in 1 (rising-edge system clock); rst in 1 (synchronous, active-high reset); btn0 in 1 (load operand A); btn1 in 1 (load operand B); t in WIDTH (operand switches).
REQ-007 SHALL have outputs: sf_e 1 (LCD/flash select); lcd_e 1 (LCD enable); lcd_rs 1 (register select); lcd_rw 1 (read/write); lcd_d 4 (data nibble); carry 1 (sum carry-out); busy 1 (write pass in progress).
REQ-008 SHALL use one clock domain, clk; rst SHALL be synchronous and active-high.

Function
REQ-009 SHALL load t into operand A on any cycle with btn0=1; SHALL load t into B with btn1=1 only when btn0=0 (btn0 wins on simultaneous press).
REQ-010 SHALL compute sum = A + B as WIDTH+1 bits, combinationally; carry = sum[WIDTH].
REQ-011 SHALL drive sf_e=1 and lcd_rw=0 permanently out of reset.
REQ-012 Main FSM states: PWR_WAIT, INIT, ADDR, DATA, IDLE.
REQ-013 PWR_WAIT: count PWR_CYC cycles, then go to INIT.
REQ-014 INIT: send nibbles 3,3,3,2 (rs=0), then bytes 0x28, 0x06, 0x0C, 0x01 (rs=0), wait CLR_CYC, go to ADDR.
REQ-015 ADDR: send byte 0x80 (rs=0) to set DDRAM address 0, then go to DATA.
REQ-016 DATA: send NDIG = WIDTH/4+1 characters (rs=1); first the carry digit ('0'/'1'), then hex digits of sum[WIDTH-1:0], most significant first; then go to IDLE.
REQ-017 Hex encoding: value 0-9 -> 0x30+value; 10-15 -> 0x41+(value-10) (uppercase).
REQ-018 Byte send = high nibble, then low nibble.
REQ-019 Nibble timing: lcd_rs/lcd_d stable 1 cycle before lcd_e rises; lcd_e high exactly E_CYC cycles; lcd_rs/lcd_d held through the following GAP_CYC cycles with lcd_e=0.
REQ-020 SHALL snapshot sum when entering ADDR; displayed characters SHALL come from the snapshot only.
REQ-021 SHALL set a dirty flag on any btn0/btn1 load; IDLE with dirty=1 SHALL clear dirty and go to ADDR next cycle.
REQ-022 A load during ADDR/DATA SHALL set dirty without aborting the pass; a rerun follows the pass.
REQ-023 busy=1 in all states except IDLE.
REQ-024 SHALL issue no lcd_e pulse while in IDLE.

Reset
REQ-025 rst=1 SHALL, on the next edge, force: FSM=PWR_WAIT, all counters=0, A=B=0, dirty=1, snapshot=0, lcd_e=0, lcd_rs=0, lcd_d=0, sf_e=0, busy=1.
REQ-026 rst asserted mid-nibble or mid-pass SHALL abandon it immediately; the sequence restarts from PWR_WAIT.
REQ-027 After the first full pass following reset, the display SHALL show all zeros (NDIG x '0').

Verification
REQ-028 WIDTH=8, PWR_CYC=20, E_CYC=2, GAP_CYC=3, CLR_CYC=5; reset release -> first lcd_e rise after exactly 21 cycles with lcd_d=3, rs=0; the INIT nibble stream is 3,3,3,2,2,8,0,6,0,C,0,1.
REQ-029 A=0xFF, B=0x01 -> carry=1; DATA nibbles 3,1,3,0,3,0 ("100"); busy falls after the last GAP.
REQ-030 A=0x3C, B=0x0E -> "04A": nibbles 3,0,3,4,4,1; carry=0.
REQ-031 btn0=btn1=1 with t=0x55 -> only A changes; B unchanged.
REQ-032 Load B=0x02 mid-DATA -> current pass completes with the old values; a second pass starts (0x80 sent) showing the new sum.
REQ-033 rst pulsed while lcd_e=1 -> lcd_e=0 next cycle, busy=1; the PWR_WAIT count restarts.

Source files
------------

// File: rtl/lcd_sum_display.sv
// Adds two operands loaded from switches and shows carry + hex sum on a 4-bit-bus
// character LCD: power-up wait, controller init, then address + data passes on demand.
module lcd_sum_display #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned E_CYC   = 12,
  parameter int unsigned GAP_CYC = 2000,
  parameter int unsigned PWR_CYC = 750000,
  parameter int unsigned CLR_CYC = 82000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn0,
  input  logic             btn1,
  input  logic [WIDTH-1:0] t,
  output logic             sf_e,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [3:0]       lcd_d,
  output logic             carry,
  output logic             busy
);
  localparam int unsigned NDIG  = WIDTH / 4 + 1;
  localparam int unsigned NDATA = 2 * NDIG;

  typedef enum logic [2:0] {PWR_WAIT, INIT, ADDR, DATA, IDLE} state_t;
  typedef enum logic [2:0] {PH_NONE, PH_SETUP, PH_E, PH_GAP, PH_CLR} phase_t;

  state_t           state, state_n, start_st;
  phase_t           phase, phase_n;
  logic [31:0]      cnt, cnt_n;
  logic [4:0]       idx, idx_n;
  logic [WIDTH-1:0] a, a_n, b, b_n;
  logic             dirty, dirty_n;
  logic [WIDTH:0]   snap, snap_n;
  logic [WIDTH:0]   sum;
  logic             e_n, rs_n, sf_n, start;
  logic [3:0]       d_n;

  assign sum = {1'b0, a} + {1'b0, b};

  // {rs, nibble} for position i of the stream belonging to state st
  function automatic logic [4:0] nib_at(state_t st, logic [4:0] i, logic [WIDTH:0] s);
    logic [7:0]  ch;
    logic [3:0]  dig;
    int unsigned k;
    int unsigned pos;
    nib_at = '0;
    case (st)
      INIT: begin
        case (i)
          5'd0, 5'd1, 5'd2: nib_at = 5'h03;
          5'd3, 5'd4:       nib_at = 5'h02;
          5'd5:             nib_at = 5'h08;
          5'd7:             nib_at = 5'h06;
          5'd9:             nib_at = 5'h0C;
          5'd11:            nib_at = 5'h01;
          default:          nib_at = 5'h00;
        endcase
      end
      ADDR: nib_at = (i == 5'd0) ? 5'h08 : 5'h00;
      DATA: begin
        k = 32'(i) >> 1;
        if (k == 0) begin
          ch = {7'h18, s[WIDTH]};
        end else begin
          pos = NDIG - 1 - k;
          dig = '0;
          for (int unsigned j = 0; j < WIDTH / 4; j++)
            if (j == pos) dig = s[4*j +: 4];
          ch = (dig < 4'd10) ? (8'h30 + {4'h0, dig}) : (8'h37 + {4'h0, dig});
        end
        nib_at = {1'b1, i[0] ? ch[3:0] : ch[7:4]};
      end
      default: nib_at = '0;
    endcase
  endfunction

  function automatic logic [4:0] last_idx(state_t st);
    case (st)
      INIT:    last_idx = 5'd11;
      ADDR:    last_idx = 5'd1;
      DATA:    last_idx = 5'(NDATA - 1);
      default: last_idx = 5'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PWR_WAIT;
      phase  <= PH_NONE;
      cnt    <= '0;
      idx    <= '0;
      a      <= '0;
      b      <= '0;
      dirty  <= 1'b1;
      snap   <= '0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_d  <= '0;
      sf_e   <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      a      <= a_n;
      b      <= b_n;
      dirty  <= dirty_n;
      snap   <= snap_n;
      lcd_e  <= e_n;
      lcd_rs <= rs_n;
      lcd_d  <= d_n;
      sf_e   <= sf_n;
    end
  end

  // Entering INIT/ADDR/DATA loads the first nibble on the same edge, so the
  // setup cycle overlaps the transition instead of costing an extra cycle.
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    cnt_n    = cnt;
    idx_n    = idx;
    a_n      = a;
    b_n      = b;
    dirty_n  = dirty;
    snap_n   = snap;
    e_n      = lcd_e;
    rs_n     = lcd_rs;
    d_n      = lcd_d;
    sf_n     = 1'b1;
    start    = 1'b0;
    start_st = state;

    if (btn0)      a_n = t;
    else if (btn1) b_n = t;

    case (state)
      PWR_WAIT: begin
        if (cnt == PWR_CYC - 1) begin
          start    = 1'b1;
          start_st = INIT;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      IDLE: begin
        if (dirty) begin
          start    = 1'b1;
          start_st = ADDR;
        end
      end
      default: begin
        case (phase)
          PH_SETUP: begin
            phase_n = PH_E;
            e_n     = 1'b1;
            cnt_n   = '0;
          end
          PH_E: begin
            if (cnt == E_CYC - 1) begin
              phase_n = PH_GAP;
              e_n     = 1'b0;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 32'd1;
            end
          end
          PH_GAP: begin
            if (cnt != GAP_CYC - 1) begin
              cnt_n = cnt + 32'd1;
            end else if (idx != last_idx(state)) begin
              idx_n         = idx + 5'd1;
              {rs_n, d_n}   = nib_at(state, idx + 5'd1, snap);
              phase_n       = PH_SETUP;
              cnt_n         = '0;
            end else begin
              case (state)
                INIT: begin
                  phase_n = PH_CLR;
                  cnt_n   = '0;
                end
                ADDR: begin
                  start    = 1'b1;
                  start_st = DATA;
                end
                default: begin
                  state_n = IDLE;
                  phase_n = PH_NONE;
                  cnt_n   = '0;
                end
              endcase
            end
          end
          PH_CLR: begin
            if (cnt == CLR_CYC - 1) begin
              start    = 1'b1;
              start_st = ADDR;
            end else begin
              cnt_n = cnt + 32'd1;
            end
          end
          default: ;
        endcase
      end
    endcase

    if (start) begin
      state_n = start_st;
      phase_n = PH_SETUP;
      cnt_n   = '0;
      idx_n   = '0;
      if (start_st == ADDR) begin
        snap_n  = sum;
        dirty_n = 1'b0;
      end
      {rs_n, d_n} = nib_at(start_st, 5'd0, snap_n);
    end

    if (btn0 || btn1) dirty_n = 1'b1;
  end

  always_comb begin
    busy   = (state != IDLE);
    carry  = sum[WIDTH];
    lcd_rw = 1'b0;
  end

endmodule

// File: tb/tb_lcd_sum_display.sv
// Directed bench for lcd_sum_display: captures every lcd_e nibble and compares
// whole passes against hand-written LCD byte streams.
module tb_lcd_sum_display;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn0 = 1'b0;
  logic       btn1 = 1'b0;
  logic [7:0] t = '0;
  logic       sf_e, lcd_e, lcd_rs, lcd_rw, carry, busy;
  logic [3:0] lcd_d;

  int checks = 0;
  int passed = 0;

  lcd_sum_display #(
    .WIDTH(8), .E_CYC(2), .GAP_CYC(3), .PWR_CYC(20), .CLR_CYC(5)
  ) dut (
    .clk(clk), .rst(rst), .btn0(btn0), .btn1(btn1), .t(t),
    .sf_e(sf_e), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_d(lcd_d), .carry(carry), .busy(busy)
  );

  always #5 clk = ~clk;

  // nibble capture and timing monitor, sampled on the falling edge
  logic [4:0] nq[$];
  logic       prev_e = 1'b0, prev_busy = 1'b1;
  logic [4:0] prev_rsd = '0;
  int         hi = 0, e_viol = 0, setup_viol = 0;
  int         cyc = 0, last_fall = 0, busy_delay = -1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hi = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        nq.push_back({lcd_rs, lcd_d});
        if ({lcd_rs, lcd_d} !== prev_rsd) setup_viol++;
      end
      if (lcd_e) hi++;
      else begin
        if (hi != 0 && hi != 2) e_viol++;
        hi = 0;
      end
      if (prev_e && !lcd_e) last_fall = cyc;
      if (prev_busy && !busy) busy_delay = cyc - last_fall;
    end
    prev_e    = lcd_e;
    prev_busy = busy;
    prev_rsd  = {lcd_rs, lcd_d};
  end

  function automatic logic [79:0] tail_nib(int n);
    logic [79:0] r = '0;
    if (nq.size() < n) return '1;
    for (int i = 0; i < n; i++) r = {r[75:0], nq[nq.size() - n + i][3:0]};
    return r;
  endfunction

  function automatic logic [19:0] tail_rs(int n);
    logic [19:0] r = '0;
    if (nq.size() < n) return '1;
    for (int i = 0; i < n; i++) r = {r[18:0], nq[nq.size() - n + i][4]};
    return r;
  endfunction

  task automatic press(input logic b0, input logic b1, input logic [7:0] v);
    @(negedge clk);
    btn0 = b0; btn1 = b1; t = v;
    @(negedge clk);
    btn0 = 1'b0; btn1 = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
      if (quiet >= 4) begin ok = 1'b1; break; end
    end
  endtask

  // returns cycles from reset release to first lcd_e high
  task automatic release_and_count(output int n);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (lcd_e) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_e, lcd_rs, lcd_d, sf_e, busy, carry, lcd_rw} !== 10'b0_0_0000_0_1_0_0)
      $display("FAIL reset_outputs got e=%b rs=%b d=%h sf_e=%b busy=%b carry=%b rw=%b want 0 0 0 0 1 0 0",
               lcd_e, lcd_rs, lcd_d, sf_e, busy, carry, lcd_rw);
    else passed++;
  endtask

  task automatic test_power_up;
    int n;
    bit ok;
    release_and_count(n);
    checks++;
    if (n !== 21) $display("FAIL first_e_latency got %0d want 21", n); else passed++;
    checks++;
    if ({lcd_rs, lcd_d} !== 5'h03) $display("FAIL first_nibble got rs=%b d=%h want rs=0 d=3", lcd_rs, lcd_d);
    else passed++;
    checks++;
    if ({sf_e, lcd_rw} !== 2'b10) $display("FAIL sf_e_rw got sf_e=%b rw=%b want 1 0", sf_e, lcd_rw); else passed++;
    wait_idle(ok);
    checks++;
    if (!ok) $display("FAIL init_idle_timeout got busy=%b want 0", busy); else passed++;
    checks++;
    if (nq.size() !== 20) $display("FAIL init_count got %0d want 20", nq.size()); else passed++;
    checks++;
    if (tail_nib(20) !== 80'h3332_2806_0C01_8030_3030)
      $display("FAIL init_stream got %h want 33322806_0C01_8030_3030", tail_nib(20));
    else passed++;
    checks++;
    if (tail_rs(20) !== 20'h0003F) $display("FAIL init_rs got %h want 0003f", tail_rs(20)); else passed++;
    checks++;
    if (busy_delay !== 3) $display("FAIL busy_fall_delay got %0d want 3", busy_delay); else passed++;
  endtask

  task automatic test_carry;
    bit ok;
    press(1'b1, 1'b0, 8'hFF);
    press(1'b0, 1'b1, 8'h01);
    checks++;
    if (carry !== 1'b1) $display("FAIL carry_ff01 got %b want 1", carry); else passed++;
    wait_idle(ok);
    checks++;
    if (!ok || tail_nib(8) !== 80'h8031_3030 || tail_rs(8) !== 20'h3F)
      $display("FAIL pass_100 got nib=%h rs=%h want 80313030 3f", tail_nib(8), tail_rs(8));
    else passed++;
  endtask

  task automatic test_hex;
    bit ok;
    press(1'b1, 1'b0, 8'h3C);
    press(1'b0, 1'b1, 8'h0E);
    checks++;
    if (carry !== 1'b0) $display("FAIL carry_3c0e got %b want 0", carry); else passed++;
    wait_idle(ok);
    checks++;
    if (!ok || tail_nib(8) !== 80'h8030_3441 || tail_rs(8) !== 20'h3F)
      $display("FAIL pass_04A got nib=%h rs=%h want 80303441 3f", tail_nib(8), tail_rs(8));
    else passed++;
  endtask

  task automatic test_simultaneous;
    bit ok;
    press(1'b1, 1'b1, 8'h55);
    wait_idle(ok);
    checks++;
    if (!ok || tail_nib(8) !== 80'h8030_3633)
      $display("FAIL both_buttons got nib=%h want 80303633 (A=55 B=0E)", tail_nib(8));
    else passed++;
  endtask

  task automatic test_midpass_load;
    bit ok = 1'b0;
    nq.delete();
    press(1'b1, 1'b0, 8'h10);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (nq.size() >= 3) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) $display("FAIL data_start_timeout got %0d nibbles want 3", nq.size()); else passed++;
    press(1'b0, 1'b1, 8'h02);
    wait_idle(ok);
    checks++;
    if (!ok || nq.size() !== 16) $display("FAIL midpass_count got %0d want 16", nq.size()); else passed++;
    checks++;
    if (tail_nib(16) !== 80'h8030_3145_8030_3132 || tail_rs(16) !== 20'h3F3F)
      $display("FAIL midpass_stream got nib=%h rs=%h want 8030314580303132 3f3f", tail_nib(16), tail_rs(16));
    else passed++;
  endtask

  task automatic test_reset_mid_e;
    bit ok = 1'b0;
    int n;
    press(1'b1, 1'b0, 8'h20);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lcd_e) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) $display("FAIL e_high_timeout got lcd_e=%b want 1", lcd_e); else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({lcd_e, busy, sf_e} !== 3'b010)
      $display("FAIL reset_mid_e got e=%b busy=%b sf_e=%b want 0 1 0", lcd_e, busy, sf_e);
    else passed++;
    nq.delete();
    release_and_count(n);
    checks++;
    if (n !== 21 || lcd_d !== 4'h3) $display("FAIL restart_latency got %0d d=%h want 21 d=3", n, lcd_d);
    else passed++;
    wait_idle(ok);
    checks++;
    if (!ok || tail_nib(20) !== 80'h3332_2806_0C01_8030_3030 || carry !== 1'b0)
      $display("FAIL restart_pass got nib=%h carry=%b want 33322806_0C01_8030_3030 0", tail_nib(20), carry);
    else passed++;
  endtask

  task automatic test_timing;
    checks++;
    if (e_viol !== 0) $display("FAIL e_width got %0d bad pulses want 0", e_viol); else passed++;
    checks++;
    if (setup_viol !== 0) $display("FAIL setup_hold got %0d bad nibbles want 0", setup_viol); else passed++;
  endtask

  initial begin
    test_reset;
    test_power_up;
    test_carry;
    test_hex;
    test_simultaneous;
    test_midpass_load;
    test_reset_mid_e;
    test_timing;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
